// File: rtl/riscv_defines.sv
`default_nettype none
// ============================================================================
// Package     : riscv_defines
// Description : Shared core widths plus memory arbiter state and grant types.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_defines;

  localparam int RISCV_ADDR_WIDTH = 32;
  localparam int RISCV_WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_id_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one memory port between fetch and LSU.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import riscv_defines::*;
#(
  parameter int ADDR_W = RISCV_ADDR_WIDTH,
  parameter int DATA_W = RISCV_WORD_WIDTH
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_valid_i,
  output logic              i_ready_o,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic [DATA_W-1:0] i_wdata_i,
  input  logic [3:0]        i_we_i,
  output logic [DATA_W-1:0] i_rdata_o,

  input  logic              d_valid_i,
  output logic              d_ready_o,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [3:0]        d_we_i,
  output logic [DATA_W-1:0] d_rdata_o,

  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_we_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  arb_state_t r_state;
  grant_id_t  r_last_grant;

  logic w_pick_d;
  logic w_pick_i;

  // Data side wins contention only when instruction side was served last.
  assign w_pick_d = d_valid_i && (!i_valid_i || (r_last_grant == GRANT_I));
  assign w_pick_i = i_valid_i && !w_pick_d;

  assign i_ready_o = !rst && (r_state == BUSY_I) && mem_ready_i;
  assign d_ready_o = !rst && (r_state == BUSY_D) && mem_ready_i;
  assign i_rdata_o = mem_rdata_i;
  assign d_rdata_o = mem_rdata_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_I;
      mem_valid_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      mem_we_o     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            r_state     <= BUSY_D;
            mem_valid_o <= 1'b1;
            mem_addr_o  <= d_addr_i;
            mem_wdata_o <= d_wdata_i;
            mem_we_o    <= d_we_i;
          end else if (w_pick_i) begin
            r_state     <= BUSY_I;
            mem_valid_o <= 1'b1;
            mem_addr_o  <= i_addr_i;
            mem_wdata_o <= i_wdata_i;
            mem_we_o    <= i_we_i;
          end
        end
        BUSY_I: begin
          if (mem_ready_i) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_I;
            mem_valid_o  <= 1'b0;
          end
        end
        BUSY_D: begin
          if (mem_ready_i) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_D;
            mem_valid_o  <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          mem_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
